// File: rtl/dm_bus_arbiter.sv
// Shares the debug module's single system-bus master port between NrReq requesters.
// Define DM_BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dm_bus_arbiter #(
    parameter int unsigned NrReq          = 2,
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrReq-1:0]                   req_i,
    input  logic [NrReq-1:0]                   we_i,
    input  logic [NrReq-1:0][BusWidth-1:0]     add_i,
    input  logic [NrReq-1:0][BusWidth-1:0]     wdata_i,
    input  logic [NrReq-1:0][BusWidth/8-1:0]   be_i,
    output logic [NrReq-1:0]                   gnt_o,
    output logic [NrReq-1:0]                   r_valid_o,
    output logic [BusWidth-1:0]                r_rdata_o,
    output logic                               master_req_o,
    output logic [BusWidth-1:0]                master_add_o,
    output logic                               master_we_o,
    output logic [BusWidth-1:0]                master_wdata_o,
    output logic [BusWidth/8-1:0]              master_be_o,
    input  logic                               master_gnt_i,
    input  logic                               master_r_valid_i,
    input  logic [BusWidth-1:0]                master_r_rdata_i,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned IdW  = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    localparam logic [IdW-1:0]  LastReq = IdW'(NrReq - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

    if (BusWidth != 32 && BusWidth != 64) begin : g_bad_width
        $fatal(1, "dm_bus_arbiter: BusWidth must be 32 or 64");
    end
    if (NrReq < 2) begin : g_bad_nrreq
        $fatal(1, "dm_bus_arbiter: NrReq must be at least 2");
    end
    if (MaxOutstanding < 1) begin : g_bad_depth
        $fatal(1, "dm_bus_arbiter: MaxOutstanding must be at least 1");
    end

    logic                              lock_q, lock_d;
    logic [IdW-1:0]                    lock_id_q, lock_id_d;
    logic [MaxOutstanding-1:0][IdW-1:0] id_q, id_d;
    logic [PtrW-1:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]                   count_q, count_d;

    logic [IdW-1:0] arb_sel, sel, head;
    logic           valid_sel, full, empty, grant, push, pop;

    // ---------------------------------------------------------------------
    // Requester selection
    // ---------------------------------------------------------------------
`ifdef DM_BUS_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_sel = '0;
        for (int i = NrReq - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                arb_sel = IdW'(i);
            end
        end
    end
`else
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] arb_cand;
    logic           arb_found;

    always_comb begin
        arb_sel   = rr_ptr_q;
        arb_found = 1'b0;
        arb_cand  = '0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            arb_cand = IdW'((32'(rr_ptr_q) + k) % NrReq);
            if (!arb_found && req_i[arb_cand]) begin
                arb_sel   = arb_cand;
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (sel == LastReq) ? '0 : sel + IdW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign sel       = lock_q ? lock_id_q : arb_sel;
    assign valid_sel = req_i[sel];
    // Stall only looks at the registered count: a same-cycle pop does not free a slot.
    assign full      = (count_q == MaxCnt);
    assign empty     = (count_q == '0);
    assign head      = id_q[rptr_q];

    // Outputs are forced low while reset is held, regardless of requester inputs.
    assign master_req_o = rst_ni & valid_sel & ~full;
    assign grant        = master_req_o & master_gnt_i;
    assign push         = grant;
    assign pop          = rst_ni & master_r_valid_i & ~empty;

    // ---------------------------------------------------------------------
    // Output routing
    // ---------------------------------------------------------------------
    always_comb begin
        gnt_o          = '0;
        r_valid_o      = '0;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        if (rst_ni && valid_sel) begin
            master_add_o   = add_i[sel];
            master_we_o    = we_i[sel];
            master_wdata_o = wdata_i[sel];
            master_be_o    = be_i[sel];
        end
        if (grant) begin
            gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            r_valid_o[head] = 1'b1;
        end
    end

    assign r_rdata_o = rst_ni ? master_r_rdata_i : '0;
    assign err_o     = rst_ni & master_r_valid_i & empty;
    assign busy_o    = rst_ni & (~empty | master_req_o);

    // ---------------------------------------------------------------------
    // Lock and response-ID FIFO
    // ---------------------------------------------------------------------
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (grant) begin
            lock_d = 1'b0;
        end else if (master_req_o) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end else if (lock_q && !req_i[lock_id_q]) begin
            // Requester withdrew before its grant; re-arbitrate next cycle.
            lock_d = 1'b0;
        end
    end

    always_comb begin
        id_d    = id_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            id_d[wptr_q] = sel;
            wptr_d       = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            id_q      <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            id_q      <= id_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed self-checking bench for dm_bus_arbiter (NrReq=2, BusWidth=32, MaxOutstanding=2).
module tb_dm_bus_arbiter;

    logic              clk_i;
    logic              rst_ni;
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [1:0][31:0]  add_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0][3:0]   be_i;
    logic [1:0]        gnt_o;
    logic [1:0]        r_valid_o;
    logic [31:0]       r_rdata_o;
    logic              master_req_o;
    logic [31:0]       master_add_o;
    logic              master_we_o;
    logic [31:0]       master_wdata_o;
    logic [3:0]        master_be_o;
    logic              master_gnt_i;
    logic              master_r_valid_i;
    logic [31:0]       master_r_rdata_i;
    logic              busy_o;
    logic              err_o;

    int n_checks = 0;
    int n_pass   = 0;

    dm_bus_arbiter #(
        .NrReq          (2),
        .BusWidth       (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (req_i),
        .we_i             (we_i),
        .add_i            (add_i),
        .wdata_i          (wdata_i),
        .be_i             (be_i),
        .gnt_o            (gnt_o),
        .r_valid_o        (r_valid_o),
        .r_rdata_o        (r_rdata_o),
        .master_req_o     (master_req_o),
        .master_add_o     (master_add_o),
        .master_we_o      (master_we_o),
        .master_wdata_o   (master_wdata_o),
        .master_be_o      (master_be_o),
        .master_gnt_i     (master_gnt_i),
        .master_r_valid_i (master_r_valid_i),
        .master_r_rdata_i (master_r_rdata_i),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [1:0] exp_gnt [4];
    logic [1:0] exp_rv  [4];

    initial begin
        rst_ni           = 1'b0;
        req_i            = 2'b11;
        we_i             = 2'b10;
        add_i[0]         = 32'h0000_0100;
        add_i[1]         = 32'h0000_0200;
        wdata_i[0]       = 32'h0000_00A0;
        wdata_i[1]       = 32'h0000_00B1;
        be_i[0]          = 4'hF;
        be_i[1]          = 4'h3;
        master_gnt_i     = 1'b1;
        master_r_valid_i = 1'b0;
        master_r_rdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset: outputs low even with requests pending.
        check("rst_master_req", 64'(master_req_o), 64'd0);
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_add", 64'(master_add_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_rvalid", 64'(r_valid_o), 64'd0);
        req_i = 2'b00;
        rst_ni = 1'b1;
        tick();

        // Round-robin arbitration, each requester drops after its grant.
        req_i = 2'b11;
        settle();
        check("arb1_gnt", 64'(gnt_o), 64'h1);
        check("arb1_add", 64'(master_add_o), 64'h100);
        check("arb1_we", 64'(master_we_o), 64'd0);
        check("arb1_wdata", 64'(master_wdata_o), 64'hA0);
        check("arb1_be", 64'(master_be_o), 64'hF);
        tick();
        req_i = 2'b10;
        settle();
        check("arb2_gnt", 64'(gnt_o), 64'h2);
        check("arb2_add", 64'(master_add_o), 64'h200);
        check("arb2_we", 64'(master_we_o), 64'd1);
        check("arb2_wdata", 64'(master_wdata_o), 64'hB1);
        check("arb2_be", 64'(master_be_o), 64'h3);
        tick();
        req_i = 2'b00;
        master_r_valid_i = 1'b1;
        master_r_rdata_i = 32'h1111_1111;
        settle();
        check("drain1_rvalid", 64'(r_valid_o), 64'h1);
        check("drain1_rdata", 64'(r_rdata_o), 64'h1111_1111);
        check("idle_add_zero", 64'(master_add_o), 64'd0);
        check("drain1_busy", 64'(busy_o), 64'd1);
        tick();
        master_r_rdata_i = 32'h2222_2222;
        settle();
        check("drain2_rvalid", 64'(r_valid_o), 64'h2);
        check("drain2_rdata", 64'(r_rdata_o), 64'h2222_2222);
        tick();
        master_r_valid_i = 1'b0;
        req_i = 2'b11;
        settle();
        check("arb3_gnt", 64'(gnt_o), 64'h1);
        tick();
        req_i = 2'b10;
        settle();
        check("arb4_gnt", 64'(gnt_o), 64'h2);
        tick();
        req_i = 2'b00;
        master_r_valid_i = 1'b1;
        tick();
        tick();
        master_r_valid_i = 1'b0;
        settle();
        check("drained_busy", 64'(busy_o), 64'd0);

        // Lock: requester 1 held while requester 0 joins.
        master_gnt_i = 1'b0;
        req_i = 2'b10;
        settle();
        check("lock1_req", 64'(master_req_o), 64'd1);
        check("lock1_add", 64'(master_add_o), 64'h200);
        check("lock1_gnt", 64'(gnt_o), 64'd0);
        tick();
        req_i = 2'b11;
        settle();
        check("lock2_add", 64'(master_add_o), 64'h200);
        check("lock2_gnt", 64'(gnt_o), 64'd0);
        tick();
        settle();
        check("lock3_add", 64'(master_add_o), 64'h200);
        master_gnt_i = 1'b1;
        settle();
        check("lock_first_gnt", 64'(gnt_o), 64'h2);
        tick();

        // Grant ID 0 second, then fill and stall.
        req_i = 2'b01;
        settle();
        check("resp_gnt0", 64'(gnt_o), 64'h1);
        tick();
        settle();
        check("full_master_req", 64'(master_req_o), 64'd0);
        check("full_gnt", 64'(gnt_o), 64'd0);
        check("full_busy", 64'(busy_o), 64'd1);
        master_r_valid_i = 1'b1;
        master_r_rdata_i = 32'hDEAD_BEEF;
        settle();
        check("resp1_rvalid", 64'(r_valid_o), 64'h2);
        check("resp1_rdata", 64'(r_rdata_o), 64'hDEAD_BEEF);
        check("pop_no_unstall", 64'(master_req_o), 64'd0);
        tick();
        master_r_rdata_i = 32'h1234_5678;
        settle();
        check("resp2_rvalid", 64'(r_valid_o), 64'h1);
        check("resp2_rdata", 64'(r_rdata_o), 64'h1234_5678);
        check("unstall_req", 64'(master_req_o), 64'd1);
        check("unstall_gnt", 64'(gnt_o), 64'h1);
        tick();
        req_i = 2'b00;
        master_r_rdata_i = 32'hCAFE_F00D;
        settle();
        check("pushpop_rvalid", 64'(r_valid_o), 64'h1);
        tick();
        master_r_valid_i = 1'b0;
        settle();
        check("resp_idle_busy", 64'(busy_o), 64'd0);

        // Spurious response.
        master_r_valid_i = 1'b1;
        settle();
        check("spur_err", 64'(err_o), 64'd1);
        check("spur_rvalid", 64'(r_valid_o), 64'd0);
        tick();
        master_r_valid_i = 1'b0;
        settle();
        check("spur_err_clear", 64'(err_o), 64'd0);
        check("spur_busy", 64'(busy_o), 64'd0);

        // Spurious response in the same cycle as the first push.
        req_i = 2'b01;
        master_r_valid_i = 1'b1;
        settle();
        check("spur_push_gnt", 64'(gnt_o), 64'h1);
        check("spur_push_err", 64'(err_o), 64'd1);
        check("spur_push_rvalid", 64'(r_valid_o), 64'd0);
        tick();
        master_r_valid_i = 1'b0;
        master_gnt_i = 1'b0;
        settle();
        check("outst_busy", 64'(busy_o), 64'd1);
        check("outst_req", 64'(master_req_o), 64'd1);

        // Asynchronous reset mid-transaction.
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_req", 64'(master_req_o), 64'd0);
        check("arst_gnt", 64'(gnt_o), 64'd0);
        check("arst_add", 64'(master_add_o), 64'd0);
        check("arst_rvalid", 64'(r_valid_o), 64'd0);
        req_i = 2'b00;
        tick();
        rst_ni = 1'b1;
        master_r_valid_i = 1'b1;
        settle();
        check("post_rst_err", 64'(err_o), 64'd1);
        check("post_rst_rvalid", 64'(r_valid_o), 64'd0);
        tick();
        master_r_valid_i = 1'b0;

        // Locked requester withdraws before grant.
        req_i = 2'b01;
        settle();
        check("drop1_req", 64'(master_req_o), 64'd1);
        check("drop1_add", 64'(master_add_o), 64'h100);
        tick();
        req_i = 2'b10;
        settle();
        check("drop2_req", 64'(master_req_o), 64'd0);
        check("drop2_add", 64'(master_add_o), 64'd0);
        tick();
        settle();
        check("drop3_req", 64'(master_req_o), 64'd1);
        check("drop3_add", 64'(master_add_o), 64'h200);
        master_gnt_i = 1'b1;
        settle();
        check("drop3_gnt", 64'(gnt_o), 64'h2);
        tick();
        req_i = 2'b00;
        master_r_valid_i = 1'b1;
        settle();
        check("drop_rvalid", 64'(r_valid_o), 64'h2);
        tick();
        master_r_valid_i = 1'b0;

        // Both requesting continuously with responses streaming back.
`ifdef DM_BUS_ARB_FIXED_PRIO_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
        exp_rv[0]  = 2'b00; exp_rv[1]  = 2'b01; exp_rv[2]  = 2'b01; exp_rv[3]  = 2'b01;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        exp_rv[0]  = 2'b00; exp_rv[1]  = 2'b01; exp_rv[2]  = 2'b10; exp_rv[3]  = 2'b01;
`endif
        req_i = 2'b11;
        master_r_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("stream%0d_gnt", i), 64'(gnt_o), 64'(exp_gnt[i]));
            check($sformatf("stream%0d_rvalid", i), 64'(r_valid_o), 64'(exp_rv[i]));
            tick();
        end
        req_i = 2'b00;
        tick();
        master_r_valid_i = 1'b0;
        settle();
        check("final_busy", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
